regfile_wb_arbiter: RTL and testbench

//  Writer side of the register-file write port (wen/waddr/wdata).

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_lq_fifo.sv | 60 ++++++
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the regfile writeback arbiter: register index, writeback request, arbiter state.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        ARB_ALU = 1'b0,
        ARB_LSU = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_lq_fifo.sv
// Load queue: DEPTH-entry synchronous FIFO of writeback requests.
// Latency: push visible at head one cycle later; no bypass.
// Backpressure: full_o from registered count; a push while full is dropped, even alongside a pop.
module wb_lq_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    nrst,
    input  logic    push_i,
    input  wb_req_t push_dat_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output wb_req_t head_o
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly PW bits so they wrap on their own at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load-return writebacks onto one registered regfile write port (RF_WB_FWD_EN adds forward taps).
// Latency: ALU accept -> rf_wen next cycle; load accept -> rf_wen two cycles later at minimum.
// Backpressure: alu_ready only when granted; lsu_ready while the load queue is not full.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            busy
`ifdef RF_WB_FWD_EN
    ,
    input  logic [AW-1:0]   fwd_raddr1,
    input  logic [AW-1:0]   fwd_raddr2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            lq_full, lq_empty, lq_push, lq_req;
    wb_req_t         lq_head, lsu_req;
    logic            grant_alu, grant_lq;
    logic            rf_wen_q, rf_wen_d;
    reg_idx_t        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    assign lsu_ready = nrst && !lq_full;
    assign lq_push   = lsu_valid && lsu_ready;
    assign lq_req    = !lq_empty;
    assign lsu_req   = '{rd: lsu_rd, data: lsu_data};

    wb_lq_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk        (clk),
        .nrst       (nrst),
        .push_i     (lq_push),
        .push_dat_i (lsu_req),
        .pop_i      (grant_lq),
        .full_o     (lq_full),
        .empty_o    (lq_empty),
        .head_o     (lq_head)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= ARB_ALU;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Only LQ losses to the ALU while in ARB_ALU count toward starvation.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (grant_lq) begin
            starve_d = '0;
            state_d  = ARB_ALU;
        end else if (state_q == ARB_ALU && lq_req && grant_alu) begin
            starve_d = starve_q + SW'(1);
            if (starve_d == SW'(STARVE_MAX)) state_d = ARB_LSU;
        end
    end

    always_comb begin
        grant_lq  = 1'b0;
        grant_alu = 1'b0;
        if (nrst) begin
            if (lq_req && (!alu_valid || state_q == ARB_LSU)) grant_lq  = 1'b1;
            else if (alu_valid)                              grant_alu = 1'b1;
        end
    end

    assign alu_ready = grant_alu;

    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_lq) begin
            rf_wen_d   = (lq_head.rd != '0);
            rf_waddr_d = lq_head.rd;
            rf_wdata_d = lq_head.data;
        end else if (grant_alu) begin
            rf_wen_d   = (alu_rd != '0);
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = lq_req || rf_wen_q;

`ifdef RF_WB_FWD_EN
    // Lets readers in the write cycle see the value the regfile is about to store.
    assign fwd_hit1  = rf_wen_q && (fwd_raddr1 == rf_waddr_q) && (fwd_raddr1 != '0);
    assign fwd_hit2  = rf_wen_q && (fwd_raddr2 == rf_waddr_q) && (fwd_raddr2 != '0);
    assign fwd_data1 = rf_wdata_q;
    assign fwd_data2 = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int LQD    = 4;
    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, rf_wen, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_raddr1, fwd_raddr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.LQ_DEPTH(LQD), .STARVE_MAX(STARVE)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_raddr1 (fwd_raddr1),
        .fwd_raddr2 (fwd_raddr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model: pending loads, losses since last LQ grant, and the expected write port.
    ent_t        lq_m[$];
    int          losses = 0;
    logic        m_wen  = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    // One clock: check ready outputs against the model, clock, advance model, check registered outputs.
    task automatic step(output bit alu_acc, output bit lsu_acc);
        int   cnt;
        bit   lq_win, alu_win, lrdy;
        ent_t e;
`ifdef RF_WB_FWD_EN
        fwd_raddr1 = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
        fwd_raddr2 = 5'($urandom_range(0, 31));
`endif
        #1;
        cnt     = lq_m.size();
        lrdy    = nrst && (cnt < LQD);
        lq_win  = nrst && (cnt > 0) && (!alu_valid || losses >= STARVE);
        alu_win = nrst && alu_valid && !lq_win;
        check_val("alu_ready", {31'd0, alu_ready}, {31'd0, alu_win});
        check_val("lsu_ready", {31'd0, lsu_ready}, {31'd0, lrdy});
`ifdef RF_WB_FWD_EN
        check_val("fwd_hit1", {31'd0, fwd_hit1},
                  {31'd0, m_wen && fwd_raddr1 == m_addr && fwd_raddr1 != 0});
        check_val("fwd_hit2", {31'd0, fwd_hit2},
                  {31'd0, m_wen && fwd_raddr2 == m_addr && fwd_raddr2 != 0});
        check_val("fwd_data1", fwd_data1, m_data);
`endif
        alu_acc = alu_win;
        lsu_acc = lsu_valid && lrdy;
        @(posedge clk);
        #1;
        if (!nrst) begin
            lq_m.delete();
            losses = 0;
            m_wen  = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (lq_win) begin
                e      = lq_m.pop_front();
                m_wen  = (e.rd != 0);
                m_addr = e.rd;
                m_data = e.data;
                losses = 0;
            end else if (alu_win) begin
                m_wen  = (alu_rd != 0);
                m_addr = alu_rd;
                m_data = alu_data;
                if (cnt > 0) losses++;
            end else begin
                m_wen = 1'b0;
            end
            if (lsu_acc) lq_m.push_back('{rd: lsu_rd, data: lsu_data});
        end
        check_val("rf_wen",   {31'd0, rf_wen}, {31'd0, m_wen});
        check_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
        check_val("rf_wdata", rf_wdata, m_data);
        check_val("busy",     {31'd0, busy}, {31'd0, (lq_m.size() > 0) || m_wen});
    endtask

    initial begin
        bit          aa, la;
        int          wr7_cnt, wr7_at, seen, idx, guard;
        logic [4:0]  order[$];

        // Reset held with both producers requesting.
        nrst = 1'b0; alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd3; alu_data = 32'h11; lsu_rd = 5'd4; lsu_data = 32'h22;
`ifdef RF_WB_FWD_EN
        fwd_raddr1 = '0; fwd_raddr2 = '0;
`endif
        step(aa, la);
        step(aa, la);
        check_val("rst_no_acc", {30'd0, aa, la}, 32'd0);

        // Single ALU write.
        nrst = 1'b1; lsu_valid = 1'b0;
        alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step(aa, la);
        check_val("alu_acc", {31'd0, aa}, 32'd1);
        check_val("alu_wdata", rf_wdata, 32'hDEADBEEF);
        alu_valid = 1'b0;
        step(aa, la);
        check_val("alu_wen_drop", {31'd0, rf_wen}, 32'd0);

        // x0 writes from both producers.
        seen = 0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hAAAA5555;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h5555AAAA;
        step(aa, la);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rf_wen) seen++;
            step(aa, la);
        end
        if (rf_wen) seen++;
        check_val("x0_no_wen", seen, 32'd0);
        check_val("x0_lq_empty", {31'd0, busy}, 32'd0);

        // Starvation: ALU saturates, one load must get through after STARVE losses.
        wr7_cnt = 0; wr7_at = -1;
        alu_valid = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
        for (int i = 0; i < 8; i++) begin
            alu_rd = 5'($urandom_range(1, 6)); alu_data = $urandom;
            step(aa, la);
            if (la) lsu_valid = 1'b0;
            if (rf_wen && rf_waddr == 5'd7) begin
                wr7_cnt++;
                wr7_at = i;
            end
        end
        check_val("starve_once", wr7_cnt, 32'd1);
        check_val("starve_slot", wr7_at, 32'd4);
        alu_valid = 1'b0;
        step(aa, la);

        // Full LQ: five back-to-back loads against a saturating ALU.
        idx = 0; guard = 0;
        order.delete();
        alu_valid = 1'b1;
        while (guard < 60 && (idx < 5 || busy)) begin
            lsu_valid = (idx < 5);
            lsu_rd    = 5'(16 + idx);
            lsu_data  = 32'hC000 + idx;
            alu_rd    = 5'($urandom_range(1, 15)); alu_data = $urandom;
            if (idx >= 5) alu_valid = 1'b0;
            step(aa, la);
            if (la) idx++;
            if (rf_wen && rf_waddr >= 5'd16 && rf_waddr <= 5'd20) order.push_back(rf_waddr);
            guard++;
        end
        check_val("full_all_acc", idx, 32'd5);
        check_val("full_nwrites", order.size(), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check_val("full_order", {27'd0, order[i]}, 16 + i);

        // Mid-operation reset discards queued loads.
        alu_valid = 1'b1; lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lsu_rd = 5'(9 + i); lsu_data = 32'hB000 + i;
            alu_rd = 5'd2; alu_data = $urandom;
            step(aa, la);
        end
        check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
        nrst = 1'b0; lsu_valid = 1'b0; alu_valid = 1'b0;
        step(aa, la);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(aa, la);
            if (rf_wen) seen++;
        end
        check_val("rst_discard", seen, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);

        // Random traffic; a request is held until accepted.
        aa = 1'b1; la = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (aa || !alu_valid) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data  = $urandom;
            end
            if (la || !lsu_valid) begin
                lsu_valid = ($urandom_range(0, 1) == 1);
                lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lsu_data  = $urandom;
            end
            nrst = ($urandom_range(0, 99) != 0);
            step(aa, la);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
